// File: rtl/adpcm_pcm_feeder.sv
`default_nettype none
// ============================================================================
// Module   : adpcm_pcm_feeder
// Purpose  : Buffers 16-bit PCM samples in a small FIFO and feeds them one at
//            a time to an adpcm encoder core with a toggle req/ack handshake.
//            Each resulting 4-bit code is forwarded downstream as a toggle push.
// Ports    : clk, rstn            clock / async active-low reset
//            enable               low = synchronous clear of all state
//            in_valid/in_pcm/in_ready   level valid/ready sample input
//            core_req/core_pcm    toggle request + held sample to the core
//            core_ack/core_adpcm  core idle flag + encoded nibble
//            nib_push/nib_adpcm   toggle push + code to the packer
//            nib_full             downstream full, stalls emission
//            level                FIFO occupancy
//            err                  sticky handshake timeout flag
// Revision : 1.0  initial release
// ============================================================================
module adpcm_pcm_feeder #(
    parameter int DEPTH_LOG2 = 3,
    parameter int TIMEOUT    = 32
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  enable,
    input  logic                  in_valid,
    input  logic signed [15:0]    in_pcm,
    output logic                  in_ready,
    output logic                  core_req,
    output logic signed [15:0]    core_pcm,
    input  logic                  core_ack,
    input  logic [3:0]            core_adpcm,
    output logic                  nib_push,
    output logic [3:0]            nib_adpcm,
    input  logic                  nib_full,
    output logic [DEPTH_LOG2:0]   level,
    output logic                  err
);

    localparam int                  c_DEPTH      = 1 << DEPTH_LOG2;
    localparam int                  c_CNT_W      = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [c_CNT_W-1:0]  c_CNT_LAST   = c_CNT_W'(TIMEOUT - 1);
    localparam logic [DEPTH_LOG2:0] c_LEVEL_FULL = {1'b1, {DEPTH_LOG2{1'b0}}};

    localparam logic [2:0] c_S_IDLE      = 3'd0;
    localparam logic [2:0] c_S_REQ       = 3'd1;
    localparam logic [2:0] c_S_WAIT_LOW  = 3'd2;
    localparam logic [2:0] c_S_WAIT_HIGH = 3'd3;
    localparam logic [2:0] c_S_EMIT      = 3'd4;

    logic signed [15:0]    r_mem [0:c_DEPTH-1];
    logic [DEPTH_LOG2-1:0] r_wr_ptr;
    logic [DEPTH_LOG2-1:0] r_rd_ptr;
    logic [DEPTH_LOG2:0]   r_level;
    logic [2:0]            r_state;
    logic [c_CNT_W-1:0]    r_cnt;
    logic                  r_core_req;
    logic signed [15:0]    r_core_pcm;
    logic                  r_nib_push;
    logic [3:0]            r_nib_adpcm;
    logic                  r_err;

    logic [2:0]            w_state_nxt;
    logic [c_CNT_W-1:0]    w_cnt_nxt;
    logic                  w_load_pcm;
    logic                  w_req_toggle;
    logic                  w_emit;
    logic                  w_timeout;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_fifo_empty;
    logic                  w_fifo_full;

    assign w_fifo_empty = (r_level == '0);
    assign w_fifo_full  = (r_level == c_LEVEL_FULL);
    assign in_ready     = enable && !w_fifo_full;
    assign w_push       = in_valid && in_ready;
    // The head sample leaves the FIFO only once its code went out, or when
    // the core stopped answering and the sample is abandoned.
    assign w_pop        = w_emit || w_timeout;

    assign core_req  = r_core_req;
    assign core_pcm  = r_core_pcm;
    assign nib_push  = r_nib_push;
    assign nib_adpcm = r_nib_adpcm;
    assign level     = r_level;
    assign err       = r_err;

    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_load_pcm   = 1'b0;
        w_req_toggle = 1'b0;
        w_emit       = 1'b0;
        w_timeout    = 1'b0;
        case (r_state)
            c_S_IDLE: begin
                // Sample is presented here so it is stable a full cycle
                // before the core latches it on the request toggle.
                if (!w_fifo_empty) begin
                    w_load_pcm  = 1'b1;
                    w_state_nxt = c_S_REQ;
                end
            end
            c_S_REQ: begin
                w_req_toggle = 1'b1;
                w_cnt_nxt    = '0;
                w_state_nxt  = c_S_WAIT_LOW;
            end
            c_S_WAIT_LOW: begin
                if (!core_ack) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = c_S_WAIT_HIGH;
                end else if (r_cnt == c_CNT_LAST) begin
                    w_timeout   = 1'b1;
                    w_state_nxt = c_S_IDLE;
                end else begin
                    w_cnt_nxt = r_cnt + c_CNT_W'(1);
                end
            end
            c_S_WAIT_HIGH: begin
                if (core_ack) begin
                    w_state_nxt = c_S_EMIT;
                end else if (r_cnt == c_CNT_LAST) begin
                    w_timeout   = 1'b1;
                    w_state_nxt = c_S_IDLE;
                end else begin
                    w_cnt_nxt = r_cnt + c_CNT_W'(1);
                end
            end
            c_S_EMIT: begin
                // Backpressure may hold here indefinitely; no timeout.
                if (!nib_full) begin
                    w_emit      = 1'b1;
                    w_state_nxt = c_S_IDLE;
                end
            end
            default: begin
                w_state_nxt = c_S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state     <= c_S_IDLE;
            r_cnt       <= '0;
            r_core_req  <= 1'b0;
            r_core_pcm  <= '0;
            r_nib_push  <= 1'b0;
            r_nib_adpcm <= 4'd0;
            r_err       <= 1'b0;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_level     <= '0;
        end else if (!enable) begin
            // The core is cleared by the same enable, so zeroing the toggles
            // keeps request/acknowledge parity aligned on both sides.
            r_state     <= c_S_IDLE;
            r_cnt       <= '0;
            r_core_req  <= 1'b0;
            r_core_pcm  <= '0;
            r_nib_push  <= 1'b0;
            r_nib_adpcm <= 4'd0;
            r_err       <= 1'b0;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_level     <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            if (w_load_pcm) begin
                r_core_pcm <= r_mem[r_rd_ptr];
            end
            if (w_req_toggle) begin
                r_core_req <= ~r_core_req;
            end
            if (w_emit) begin
                r_nib_adpcm <= core_adpcm;
                r_nib_push  <= ~r_nib_push;
            end
            if (w_timeout) begin
                r_err <= 1'b1;
            end
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + DEPTH_LOG2'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + DEPTH_LOG2'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + (DEPTH_LOG2 + 1)'(1);
                2'b01:   r_level <= r_level - (DEPTH_LOG2 + 1)'(1);
                default: r_level <= r_level;
            endcase
        end
    end

    // Sample storage needs no reset: occupancy alone says what is valid.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= in_pcm;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_adpcm_pcm_feeder.sv
`default_nettype none
// ============================================================================
// Module   : tb_adpcm_pcm_feeder
// Purpose  : Self-checking bench for adpcm_pcm_feeder. A behavioural IMA
//            encoder core answers the toggle handshake; a queue of accepted
//            samples plus a software IMA encoder give the expected codes.
// Revision : 1.0  initial release
// ============================================================================
module tb_adpcm_pcm_feeder;

    localparam int DEPTH_LOG2 = 3;
    localparam int TIMEOUT    = 32;

    localparam int STEP_TBL [0:88] = '{
        7, 8, 9, 10, 11, 12, 13, 14, 16, 17,
        19, 21, 23, 25, 28, 31, 34, 37, 41, 45,
        50, 55, 60, 66, 73, 80, 88, 97, 107, 118,
        130, 143, 157, 173, 190, 209, 230, 253, 279, 307,
        337, 371, 408, 449, 494, 544, 598, 658, 724, 796,
        876, 963, 1060, 1166, 1282, 1411, 1552, 1707, 1878, 2066,
        2272, 2499, 2749, 3024, 3327, 3660, 4026, 4428, 4871, 5358,
        5894, 6484, 7132, 7845, 8630, 9493, 10442, 11487, 12635, 13899,
        15289, 16818, 18500, 20350, 22385, 24623, 27086, 29794, 32767};
    localparam int IDX_TBL [0:7] = '{-1, -1, -1, -1, 2, 4, 6, 8};

    logic                 clk = 1'b0;
    logic                 rstn = 1'b0;
    logic                 enable = 1'b0;
    logic                 in_valid = 1'b0;
    logic signed [15:0]   in_pcm = '0;
    logic                 in_ready;
    logic                 core_req;
    logic signed [15:0]   core_pcm;
    logic                 core_ack;
    logic [3:0]           core_adpcm;
    logic                 nib_push;
    logic [3:0]           nib_adpcm;
    logic                 nib_full = 1'b0;
    logic [DEPTH_LOG2:0]  level;
    logic                 err;

    int                   n_checks = 0;
    int                   n_pass = 0;
    int                   cyc = 0;
    logic                 last_push = 1'b0;
    int                   tog_cyc [$];
    logic [3:0]           tog_code [$];
    logic signed [15:0]   pend [$];
    logic signed [15:0]   m_pred = '0;
    int                   m_idx = 0;
    logic                 stub_dead = 1'b0;

    adpcm_pcm_feeder #(.DEPTH_LOG2(DEPTH_LOG2), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rstn(rstn), .enable(enable),
        .in_valid(in_valid), .in_pcm(in_pcm), .in_ready(in_ready),
        .core_req(core_req), .core_pcm(core_pcm),
        .core_ack(core_ack), .core_adpcm(core_adpcm),
        .nib_push(nib_push), .nib_adpcm(nib_adpcm), .nib_full(nib_full),
        .level(level), .err(err)
    );

    always #5 clk = ~clk;

    // One IMA ADPCM encoder step: returns {code, 0, new index[6:0], new predictor}.
    function automatic logic [27:0] ima_step(input logic signed [15:0] s,
                                             input logic signed [15:0] pred,
                                             input int idx);
        int step, diff, vp, p, ni;
        logic [3:0] code;
        step = STEP_TBL[idx];
        diff = int'(s) - int'(pred);
        code = 4'd0;
        if (diff < 0) begin code = 4'd8; diff = -diff; end
        vp = step >>> 3;
        if (diff >= step) begin code = code | 4'd4; diff = diff - step; vp = vp + step; end
        step = step >>> 1;
        if (diff >= step) begin code = code | 4'd2; diff = diff - step; vp = vp + step; end
        step = step >>> 1;
        if (diff >= step) begin code = code | 4'd1; vp = vp + step; end
        p = code[3] ? int'(pred) - vp : int'(pred) + vp;
        if (p > 32767) p = 32767;
        if (p < -32768) p = -32768;
        ni = idx + IDX_TBL[code[2:0]];
        if (ni < 0) ni = 0;
        if (ni > 88) ni = 88;
        return {code, 1'b0, ni[6:0], p[15:0]};
    endfunction

    function automatic logic [3:0] model_code(input logic signed [15:0] s);
        logic [27:0] r;
        r = ima_step(s, m_pred, m_idx);
        m_pred = r[15:0];
        m_idx = int'(r[22:16]);
        return r[27:24];
    endfunction

    // Behavioural encoder core: ack falls on the edge after a request toggle,
    // rises 7 edges later with the code for the latched sample.
    logic               s_last_req;
    logic               s_busy;
    int                 s_cnt;
    logic signed [15:0] s_pcm;
    logic signed [15:0] s_pred;
    int                 s_idx;
    logic [27:0]        stub_res;
    assign stub_res = ima_step(s_pcm, s_pred, s_idx);

    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            core_ack <= 1'b1; core_adpcm <= 4'd0; s_last_req <= 1'b0; s_busy <= 1'b0;
            s_cnt <= 0; s_pcm <= '0; s_pred <= '0; s_idx <= 0;
        end else if (!enable || stub_dead) begin
            core_ack <= 1'b1; s_busy <= 1'b0; s_last_req <= core_req;
            if (!enable) begin s_pred <= '0; s_idx <= 0; core_adpcm <= 4'd0; end
        end else if (!s_busy) begin
            if (core_req !== s_last_req) begin
                s_last_req <= core_req; s_pcm <= core_pcm; core_ack <= 1'b0;
                s_busy <= 1'b1; s_cnt <= 0;
            end
        end else if (s_cnt == 6) begin
            core_ack <= 1'b1; s_busy <= 1'b0; core_adpcm <= stub_res[27:24];
            s_pred <= stub_res[15:0]; s_idx <= int'(stub_res[22:16]);
        end else begin
            s_cnt <= s_cnt + 1;
        end
    end

    // Advance one clock: log accepted samples and observed nib_push toggles.
    task automatic tick();
        if (rstn && enable && in_valid && in_ready) pend.push_back(in_pcm);
        @(posedge clk);
        #1;
        cyc++;
        if (!rstn || !enable) last_push = nib_push;
        else if (nib_push !== last_push) begin
            tog_cyc.push_back(cyc);
            tog_code.push_back(nib_adpcm);
            last_push = nib_push;
        end
    endtask

    task automatic test_reset();
        rstn = 1'b0; enable = 1'b0;
        repeat (3) tick();
        n_checks++; if (core_req !== 1'b0) $display("FAIL reset_core_req: got %b want 0", core_req); else n_pass++;
        n_checks++; if (core_pcm !== 16'sd0) $display("FAIL reset_core_pcm: got %h want 0", core_pcm); else n_pass++;
        n_checks++; if (nib_push !== 1'b0) $display("FAIL reset_nib_push: got %b want 0", nib_push); else n_pass++;
        n_checks++; if (nib_adpcm !== 4'd0) $display("FAIL reset_nib_adpcm: got %h want 0", nib_adpcm); else n_pass++;
        n_checks++; if (level !== 4'd0) $display("FAIL reset_level: got %0d want 0", level); else n_pass++;
        n_checks++; if (err !== 1'b0) $display("FAIL reset_err: got %b want 0", err); else n_pass++;
        n_checks++; if (in_ready !== 1'b0) $display("FAIL reset_in_ready: got %b want 0", in_ready); else n_pass++;
        rstn = 1'b1;
        tick();
        enable = 1'b1;
        tick();
        n_checks++; if (in_ready !== 1'b1) $display("FAIL enabled_in_ready: got %b want 1", in_ready); else n_pass++;
    endtask

    task automatic test_single();
        int e, guard;
        logic [3:0] got, expc;
        tog_cyc.delete();
        in_valid = 1'b1; in_pcm = 16'sd1000;
        tick(); e = cyc; in_valid = 1'b0;
        tick();
        n_checks++; if (core_pcm !== 16'sd1000) $display("FAIL single_core_pcm: got %0d want 1000", core_pcm); else n_pass++;
        n_checks++; if (core_req !== 1'b0) $display("FAIL single_req_early: got %b want 0", core_req); else n_pass++;
        tick();
        n_checks++; if (core_req !== 1'b1) $display("FAIL single_req_toggle: got %b want 1", core_req); else n_pass++;
        guard = 0;
        while (tog_cyc.size() == 0 && guard < 40) begin tick(); guard++; end
        n_checks++;
        if (tog_cyc.size() != 1) $display("FAIL single_push_count: got %0d want 1", tog_cyc.size());
        else if (tog_cyc[0] - e != 12) $display("FAIL single_latency: got %0d want 12", tog_cyc[0] - e);
        else n_pass++;
        if (tog_code.size() > 0) begin
            n_checks++; if (tog_code[0] !== 4'h7) $display("FAIL single_code_1000: got %h want 7", tog_code[0]); else n_pass++;
        end
        while (tog_code.size() > 0) begin
            got = tog_code.pop_front(); n_checks++;
            if (pend.size() == 0) $display("FAIL single_code: got %h with no sample pending", got);
            else begin
                expc = model_code(pend.pop_front());
                if (got !== expc) $display("FAIL single_code: got %h want %h", got, expc); else n_pass++;
            end
        end
        n_checks++; if (level !== 4'd0) $display("FAIL single_level_end: got %0d want 0", level); else n_pass++;
    endtask

    task automatic test_burst();
        int e, guard;
        logic [3:0] got, expc;
        tog_cyc.delete();
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1; in_pcm = 16'($urandom);
            tick();
            if (i == 0) e = cyc;
        end
        n_checks++; if (level !== 4'd8) $display("FAIL burst_level_full: got %0d want 8", level); else n_pass++;
        n_checks++; if (in_ready !== 1'b0) $display("FAIL burst_in_ready_full: got %b want 0", in_ready); else n_pass++;
        in_pcm = 16'($urandom);
        tick(); tick();
        in_valid = 1'b0;
        n_checks++; if (level !== 4'd8) $display("FAIL burst_push_while_full: got %0d want 8", level); else n_pass++;
        guard = 0;
        while (tog_cyc.size() < 8 && guard < 150) begin tick(); guard++; end
        repeat (30) tick();
        n_checks++; if (tog_cyc.size() != 8) $display("FAIL burst_push_count: got %0d want 8", tog_cyc.size()); else n_pass++;
        for (int i = 0; i < tog_cyc.size(); i++) begin
            n_checks++;
            if (tog_cyc[i] - e != 12 * (i + 1))
                $display("FAIL burst_spacing: toggle %0d at offset %0d want %0d", i, tog_cyc[i] - e, 12 * (i + 1));
            else n_pass++;
        end
        while (tog_code.size() > 0) begin
            got = tog_code.pop_front(); n_checks++;
            if (pend.size() == 0) $display("FAIL burst_code: got %h with no sample pending", got);
            else begin
                expc = model_code(pend.pop_front());
                if (got !== expc) $display("FAIL burst_code: got %h want %h", got, expc); else n_pass++;
            end
        end
    endtask

    task automatic test_backpressure();
        int e, guard;
        logic [3:0] got, expc;
        tog_cyc.delete();
        nib_full = 1'b1;
        in_valid = 1'b1; in_pcm = 16'($urandom);
        tick(); e = cyc;
        in_pcm = 16'($urandom);
        tick(); in_valid = 1'b0;
        while (cyc < e + 31) tick();
        n_checks++; if (tog_cyc.size() != 0) $display("FAIL bp_held: got %0d pushes want 0", tog_cyc.size()); else n_pass++;
        n_checks++; if (level !== 4'd2) $display("FAIL bp_level: got %0d want 2", level); else n_pass++;
        nib_full = 1'b0;
        tick();
        n_checks++;
        if (tog_cyc.size() != 1 || tog_cyc[0] != e + 32) $display("FAIL bp_release: got %0d pushes at last cycle %0d want 1 at %0d", tog_cyc.size(), cyc, e + 32);
        else n_pass++;
        guard = 0;
        while (tog_cyc.size() < 2 && guard < 40) begin tick(); guard++; end
        repeat (20) tick();
        n_checks++;
        if (tog_cyc.size() != 2) $display("FAIL bp_count: got %0d want 2", tog_cyc.size());
        else if (tog_cyc[1] != e + 44) $display("FAIL bp_second: got offset %0d want 44", tog_cyc[1] - e);
        else n_pass++;
        while (tog_code.size() > 0) begin
            got = tog_code.pop_front(); n_checks++;
            if (pend.size() == 0) $display("FAIL bp_code: got %h with no sample pending", got);
            else begin
                expc = model_code(pend.pop_front());
                if (got !== expc) $display("FAIL bp_code: got %h want %h", got, expc); else n_pass++;
            end
        end
    endtask

    task automatic test_timeout();
        int e;
        tog_cyc.delete();
        stub_dead = 1'b1;
        in_valid = 1'b1; in_pcm = 16'($urandom);
        tick(); e = cyc; in_valid = 1'b0;
        if (pend.size() > 0) void'(pend.pop_back());
        while (cyc < e + 33) tick();
        n_checks++; if (err !== 1'b0) $display("FAIL timeout_early: got err %b want 0", err); else n_pass++;
        tick();
        n_checks++; if (err !== 1'b1) $display("FAIL timeout_err: got %b want 1", err); else n_pass++;
        n_checks++; if (level !== 4'd0) $display("FAIL timeout_level: got %0d want 0", level); else n_pass++;
        repeat (20) tick();
        n_checks++; if (tog_cyc.size() != 0) $display("FAIL timeout_no_push: got %0d want 0", tog_cyc.size()); else n_pass++;
        n_checks++; if (err !== 1'b1) $display("FAIL timeout_sticky: got %b want 1", err); else n_pass++;
        enable = 1'b0;
        tick();
        n_checks++; if (err !== 1'b0) $display("FAIL timeout_clear: got %b want 0", err); else n_pass++;
        pend.delete(); m_pred = '0; m_idx = 0;
        stub_dead = 1'b0; enable = 1'b1;
        tick();
    endtask

    task automatic test_enable_abort();
        int e, guard;
        logic [3:0] got, expc;
        tog_cyc.delete();
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; in_pcm = 16'($urandom);
            tick();
            if (i == 0) e = cyc;
        end
        in_valid = 1'b0;
        while (cyc < e + 6) tick();
        enable = 1'b0;
        tick();
        n_checks++; if (level !== 4'd0) $display("FAIL abort_level: got %0d want 0", level); else n_pass++;
        n_checks++; if (core_req !== 1'b0) $display("FAIL abort_core_req: got %b want 0", core_req); else n_pass++;
        n_checks++; if (in_ready !== 1'b0) $display("FAIL abort_in_ready: got %b want 0", in_ready); else n_pass++;
        n_checks++; if (nib_push !== 1'b0) $display("FAIL abort_nib_push: got %b want 0", nib_push); else n_pass++;
        n_checks++; if (core_pcm !== 16'sd0) $display("FAIL abort_core_pcm: got %h want 0", core_pcm); else n_pass++;
        tick();
        pend.delete(); m_pred = '0; m_idx = 0;
        enable = 1'b1;
        tick();
        n_checks++; if (tog_cyc.size() != 0) $display("FAIL abort_no_push: got %0d want 0", tog_cyc.size()); else n_pass++;
        in_valid = 1'b1; in_pcm = 16'($urandom);
        tick(); e = cyc; in_valid = 1'b0;
        guard = 0;
        while (tog_cyc.size() == 0 && guard < 40) begin tick(); guard++; end
        n_checks++;
        if (tog_cyc.size() != 1 || tog_cyc[0] - e != 12) $display("FAIL abort_reenable_latency: got %0d pushes, last cycle offset %0d want 1 at 12", tog_cyc.size(), cyc - e);
        else n_pass++;
        while (tog_code.size() > 0) begin
            got = tog_code.pop_front(); n_checks++;
            if (pend.size() == 0) $display("FAIL abort_code: got %h with no sample pending", got);
            else begin
                expc = model_code(pend.pop_front());
                if (got !== expc) $display("FAIL abort_code: got %h want %h", got, expc); else n_pass++;
            end
        end
    endtask

    task automatic test_simultaneous();
        int e, guard;
        logic [3:0] got, expc;
        tog_cyc.delete();
        in_valid = 1'b1; in_pcm = 16'($urandom);
        tick(); e = cyc;
        in_pcm = 16'($urandom);
        tick(); in_valid = 1'b0;
        while (cyc < e + 11) tick();
        n_checks++; if (level !== 4'd2) $display("FAIL simul_level_before: got %0d want 2", level); else n_pass++;
        in_valid = 1'b1; in_pcm = 16'($urandom);
        tick(); in_valid = 1'b0;
        n_checks++; if (level !== 4'd2) $display("FAIL simul_level_after: got %0d want 2", level); else n_pass++;
        n_checks++;
        if (tog_cyc.size() != 1 || tog_cyc[0] != e + 12) $display("FAIL simul_pop_edge: got %0d pushes want 1 at offset 12", tog_cyc.size());
        else n_pass++;
        guard = 0;
        while (tog_cyc.size() < 3 && guard < 60) begin tick(); guard++; end
        n_checks++; if (tog_cyc.size() != 3) $display("FAIL simul_count: got %0d want 3", tog_cyc.size()); else n_pass++;
        while (tog_code.size() > 0) begin
            got = tog_code.pop_front(); n_checks++;
            if (pend.size() == 0) $display("FAIL simul_code: got %h with no sample pending", got);
            else begin
                expc = model_code(pend.pop_front());
                if (got !== expc) $display("FAIL simul_code: got %h want %h", got, expc); else n_pass++;
            end
        end
    endtask

    task automatic test_random();
        int guard;
        logic [3:0] got, expc;
        tog_cyc.delete();
        for (int i = 0; i < 400; i++) begin
            in_valid = ($urandom_range(0, 3) == 0);
            in_pcm = 16'($urandom);
            nib_full = ($urandom_range(0, 3) == 0);
            tick();
        end
        in_valid = 1'b0; nib_full = 1'b0;
        guard = 0;
        while (level != 0 && guard < 300) begin tick(); guard++; end
        repeat (30) tick();
        while (tog_code.size() > 0) begin
            got = tog_code.pop_front(); n_checks++;
            if (pend.size() == 0) $display("FAIL random_code: got %h with no sample pending", got);
            else begin
                expc = model_code(pend.pop_front());
                if (got !== expc) $display("FAIL random_code: got %h want %h", got, expc); else n_pass++;
            end
        end
        n_checks++; if (pend.size() != 0) $display("FAIL random_lost: got %0d samples never emitted want 0", pend.size()); else n_pass++;
        n_checks++; if (err !== 1'b0) $display("FAIL random_err: got %b want 0", err); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_single();
        test_burst();
        test_backpressure();
        test_timeout();
        test_enable_abort();
        test_simultaneous();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation still running at cycle %0d, want finished", cyc);
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
